sram32_be_stream_ctrl: RTL and testbench

- Valid/ready front-end for the 32-bit byte-enable banked SRAM (1 write port, 1 read port; single-port banks selected by upper address bits).
- Converts independent write and read request streams into SRAM port 0/1 cycles.
- Arbitrates same-bank collisions.
- Captures fixed one-cycle read data into a credit-controlled response FIFO so downstream backpressure never loses data.

---
 rtl/sram32_be_stream_ctrl.sv | 131 +++++++++++++
 tb/tb_sram32_be_stream_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram32_be_stream_ctrl.sv
// Valid/ready front-end for a 32-bit byte-enable banked SRAM: same-bank arbitration, read credit, response FIFO.
// Read data reaches rsp_* two cycles after the request handshake; reads stall when the response FIFO has no credit.

module sram32_rsp_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          rstn,
  input  logic          push_vld,
  input  logic [W-1:0]  push_dat,
  input  logic          pop_rdy,
  output logic          pop_vld,
  output logic [W-1:0]  pop_dat,
  output logic [CW-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop;

  assign pop_vld = (count != '0);
  assign pop     = pop_vld & pop_rdy;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge CLK or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (pop)      rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      count <= count + CW'(push_vld) - CW'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end
endmodule

module sram32_be_stream_ctrl #(
  parameter int ABITS    = 17,
  parameter int BANK_LSB = 13,
  parameter int DEPTH    = 2
) (
  input  logic             CLK,
  input  logic             rstn,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [ABITS-1:0] wr_addr,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_be,
  input  logic             rd_valid,
  output logic             rd_ready,
  input  logic [ABITS-1:0] rd_addr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             CE0,
  output logic [ABITS-1:0] A0,
  output logic [31:0]      D0,
  output logic             WE0,
  output logic [31:0]      WEM0,
  output logic             CE1,
  output logic [ABITS-1:0] A1,
  input  logic [31:0]      Q1
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic          prio;
  logic          inflight;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic          pop;
  logic          rd_space;
  logic          conflict;
  logic          wr_fire;
  logic          rd_fire;
  logic [31:0]   wmask;

  // Q1 is captured unconditionally one cycle after a read issue; credit guarantees room.
  sram32_rsp_fifo #(.W(32), .DEPTH(DEPTH), .CW(CW)) u_rsp_fifo (
    .CLK      (CLK),
    .rstn     (rstn),
    .push_vld (inflight),
    .push_dat (Q1),
    .pop_rdy  (rsp_ready),
    .pop_vld  (rsp_valid),
    .pop_dat  (rsp_data),
    .count    (count)
  );

  always_comb begin
    occ      = {1'b0, count} + {{CW{1'b0}}, inflight};
    pop      = rsp_valid & rsp_ready;
    // A pop this cycle frees the slot the new read will need two cycles later.
    rd_space = (occ < DEPTH_W) | (pop & (occ == DEPTH_W));
    conflict = wr_valid & rd_valid & rd_space &
               (wr_addr[ABITS-1:BANK_LSB] == rd_addr[ABITS-1:BANK_LSB]);
    wr_ready = rstn & (~conflict | prio);
    rd_ready = rstn & rd_space & (~conflict | ~prio);
    wr_fire  = wr_valid & wr_ready;
    rd_fire  = rd_valid & rd_ready;
    for (int i = 0; i < 4; i++) wmask[8*i +: 8] = {8{wr_be[i]}};
  end

  assign CE0  = wr_fire;
  assign WE0  = wr_fire;
  assign WEM0 = wr_fire ? wmask : '0;
  assign A0   = rstn ? wr_addr : '0;
  assign D0   = rstn ? wr_data : '0;
  assign CE1  = rd_fire;
  assign A1   = rstn ? rd_addr : '0;

  always_ff @(posedge CLK or negedge rstn) begin
    if (!rstn) begin
      prio     <= 1'b0;
      inflight <= 1'b0;
    end else begin
      prio     <= prio ^ conflict;
      inflight <= rd_fire;
    end
  end
endmodule

// File: tb/tb_sram32_be_stream_ctrl.sv
// Bench for sram32_be_stream_ctrl: SRAM model, queue-based response reference, vector table and directed sequences.
module tb_sram32_be_stream_ctrl;
  localparam int ABITS = 17;
  localparam int DEPTH = 2;

  logic             CLK = 1'b0;
  logic             rstn = 1'b0;
  logic             wr_valid, wr_ready, rd_valid, rd_ready;
  logic [ABITS-1:0] wr_addr, rd_addr;
  logic [31:0]      wr_data;
  logic [3:0]       wr_be;
  logic             rsp_valid, rsp_ready;
  logic [31:0]      rsp_data;
  logic             CE0, WE0, CE1;
  logic [ABITS-1:0] A0, A1;
  logic [31:0]      D0, WEM0;
  logic [31:0]      Q1 = '0;

  int total = 0;
  int bad = 0;

  sram32_be_stream_ctrl #(.ABITS(ABITS), .BANK_LSB(13), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .rstn(rstn),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .CE0(CE0), .A0(A0), .D0(D0), .WE0(WE0), .WEM0(WEM0),
    .CE1(CE1), .A1(A1), .Q1(Q1)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  // SRAM device model driven purely by the DUT's pins
  bit [31:0] sram_mem [131072];
  always @(posedge CLK) begin
    if (CE1) Q1 <= sram_mem[A1];
    if (CE0 && WE0) sram_mem[A0] <= (sram_mem[A0] & ~WEM0) | (D0 & WEM0);
  end

  // Reference: memory updated from handshakes, queue of outstanding responses
  typedef struct { logic [31:0] d; int acc; } rsp_t;
  bit [31:0] ref_mem [131072];
  rsp_t      q[$];
  bit        m_prio;
  int        m_cyc;
  bit        e_wf, e_rf, e_pop, e_conf;

  always @(negedge CLK) begin
    bit vis, space, conf, ewr, erd;
    if (!rstn) begin
      e_wf = 0; e_rf = 0; e_pop = 0; e_conf = 0;
      check("rst_wr_ready", wr_ready, 0);
      check("rst_rd_ready", rd_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_ce0", CE0, 0);
      check("rst_we0", WE0, 0);
      check("rst_ce1", CE1, 0);
    end else begin
      vis   = (q.size() > 0) && (m_cyc >= q[0].acc + 2);
      space = (q.size() < DEPTH) || (q.size() == DEPTH && vis && rsp_ready);
      conf  = wr_valid && rd_valid && space && (wr_addr[16:13] == rd_addr[16:13]);
      ewr   = !conf || m_prio;
      erd   = space && (!conf || !m_prio);
      e_wf  = wr_valid && ewr;
      e_rf  = rd_valid && erd;
      e_pop = vis && rsp_ready;
      e_conf = conf;
      check("mon_wr_ready", wr_ready, ewr);
      check("mon_rd_ready", rd_ready, erd);
      check("mon_rsp_valid", rsp_valid, vis);
      if (vis) check("mon_rsp_data", rsp_data, q[0].d);
      check("mon_ce0", CE0, e_wf);
      check("mon_we0", WE0, e_wf);
      check("mon_ce1", CE1, e_rf);
      check("mon_a1", A1, rd_addr);
      if (e_wf) begin
        check("mon_a0", A0, wr_addr);
        check("mon_d0", D0, wr_data);
        check("mon_wem0", WEM0, be_mask(wr_be));
      end
    end
  end

  always @(posedge CLK or negedge rstn) begin
    if (!rstn) begin
      q.delete();
      m_prio = 0;
      m_cyc = 0;
    end else begin
      if (e_rf) q.push_back('{d: ref_mem[rd_addr], acc: m_cyc});
      if (e_wf) ref_mem[wr_addr] = (ref_mem[wr_addr] & ~be_mask(wr_be)) | (wr_data & be_mask(wr_be));
      if (e_pop) void'(q.pop_front());
      if (e_conf) m_prio = ~m_prio;
      m_cyc++;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    wr_valid = 0; rd_valid = 0; wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
  endtask

  task automatic do_reset();
    rstn = 0;
    tick(); tick();
    rstn = 1;
  endtask

  task automatic wr(input logic [16:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_valid = 1; wr_addr = a; wr_data = d; wr_be = be;
  endtask

  typedef struct {
    logic wv, rv; logic [16:0] wa, ra; logic [3:0] be;
    logic ewr, erd; logic [31:0] ewem;
  } vec_t;
  vec_t vt[9];

  initial begin
    int acc, n;
    logic [31:0] sd [16];
    vt[0] = '{1, 0, 17'h00010, 17'h00000, 4'hF, 1, 1, 32'hFFFFFFFF};
    vt[1] = '{1, 1, 17'h02000, 17'h02004, 4'h5, 0, 1, 32'h0};
    vt[2] = '{1, 1, 17'h02000, 17'h04000, 4'h3, 1, 1, 32'h0000FFFF};
    vt[3] = '{0, 1, 17'h02000, 17'h02000, 4'h0, 1, 1, 32'h0};
    vt[4] = '{1, 0, 17'h00040, 17'h00000, 4'h0, 1, 1, 32'h0};
    vt[5] = '{1, 1, 17'h1FFFF, 17'h1E000, 4'hF, 0, 1, 32'h0};
    vt[6] = '{1, 1, 17'h01FFF, 17'h02000, 4'hC, 1, 1, 32'hFFFF0000};
    vt[7] = '{1, 1, 17'h06001, 17'h08001, 4'h8, 1, 1, 32'hFF000000};
    vt[8] = '{0, 0, 17'h00000, 17'h00000, 4'h0, 1, 1, 32'h0};

    idle(); rsp_ready = 1; rstn = 0;
    #2;
    check("reset_wr_ready", wr_ready, 0);
    check("reset_rd_ready", rd_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_ce0", CE0, 0);
    check("reset_ce1", CE1, 0);
    tick(); tick();
    rstn = 1;

    // Vector table: combinational grants from the freshly reset state
    for (int i = 0; i < 9; i++) begin
      rstn = 0; #1; rstn = 1; #1;
      wr_valid = vt[i].wv; rd_valid = vt[i].rv; wr_addr = vt[i].wa; rd_addr = vt[i].ra;
      wr_be = vt[i].be; wr_data = 32'h5A5A0000 + i;
      #1;
      check($sformatf("vec%0d_wr_ready", i), wr_ready, vt[i].ewr);
      check($sformatf("vec%0d_rd_ready", i), rd_ready, vt[i].erd);
      check($sformatf("vec%0d_ce0", i), CE0, vt[i].wv & vt[i].ewr);
      check($sformatf("vec%0d_ce1", i), CE1, vt[i].rv & vt[i].erd);
      if (vt[i].wv && vt[i].ewr) check($sformatf("vec%0d_wem0", i), WEM0, vt[i].ewem);
      idle();
      tick();
    end

    // Full write then read back
    wr(17'h00010, 32'hDEADBEEF, 4'hF);
    @(negedge CLK);
    check("a_ce0", CE0, 1);
    check("a_wem0", WEM0, 32'hFFFFFFFF);
    tick(); idle();
    rd_valid = 1; rd_addr = 17'h00010;
    @(negedge CLK);
    check("a_ce1", CE1, 1);
    tick(); idle();
    @(negedge CLK);
    check("a_rsp_early", rsp_valid, 0);
    tick();
    @(negedge CLK);
    check("a_rsp_valid", rsp_valid, 1);
    check("a_rsp_data", rsp_data, 32'hDEADBEEF);
    tick();

    // Partial byte-enable write
    wr(17'h00020, 32'h11223344, 4'hF);
    tick();
    wr(17'h00020, 32'hAABBCCDD, 4'b0101);
    @(negedge CLK);
    check("b_wem0", WEM0, 32'h00FF00FF);
    tick(); idle();
    rd_valid = 1; rd_addr = 17'h00020;
    tick(); idle(); tick();
    @(negedge CLK);
    check("b_rsp_data", rsp_data, 32'h11BB33DD);
    tick();

    // Same-bank alternation, then different banks
    do_reset();
    wr(17'h02000, 32'h01020304, 4'hF);
    rd_valid = 1; rd_addr = 17'h02004;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check($sformatf("c_grant%0d", i), {wr_ready, rd_ready}, (i % 2) ? 2'b10 : 2'b01);
      tick();
    end
    rd_addr = 17'h04000;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check($sformatf("c_both%0d", i), {wr_ready, rd_ready}, 2'b11);
      tick();
    end
    idle(); tick(); tick(); tick();

    // Backpressure and pop-through
    for (int k = 0; k < 3; k++) begin
      wr(17'h00300 + 17'(k), 32'hB0000000 + k, 4'hF);
      tick();
    end
    idle();
    do_reset();
    rsp_ready = 0; acc = 0;
    rd_valid = 1; rd_addr = 17'h00300;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (rd_ready) acc++;
      tick();
      rd_addr = 17'h00300 + 17'(acc);
    end
    check("d_accepted", acc, 2);
    @(negedge CLK);
    check("d_rd_stall", rd_ready, 0);
    check("d_rsp_valid", rsp_valid, 1);
    tick();
    rsp_ready = 1;
    @(negedge CLK);
    check("d_popthrough", rd_ready, 1);
    check("d_rsp0", rsp_data, 32'hB0000000);
    tick();
    rsp_ready = 0; rd_valid = 0; n = 1;
    tick();
    rsp_ready = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (rsp_valid) begin
        check($sformatf("d_rsp%0d", n), rsp_data, 32'hB0000000 + n);
        n++;
      end
      tick();
    end
    check("d_rsp_count", n, 3);

    // Streaming reads across 16 banks
    for (int b = 0; b < 16; b++) begin
      sd[b] = $urandom;
      wr(17'(b << 13) | 17'(b + 5), sd[b], 4'hF);
      tick();
    end
    idle();
    for (int t = 0; t < 20; t++) begin
      rd_valid = (t < 16);
      rd_addr = (t < 16) ? (17'(t << 13) | 17'(t + 5)) : '0;
      @(negedge CLK);
      if (t < 16) check($sformatf("e_rd_ready%0d", t), rd_ready, 1);
      if (t >= 2 && t < 18) begin
        check($sformatf("e_rsp_valid%0d", t - 2), rsp_valid, 1);
        check($sformatf("e_rsp_data%0d", t - 2), rsp_data, sd[t-2]);
      end
      tick();
    end
    idle();

    // Reset while a read is in flight
    rd_valid = 1; rd_addr = 17'h00010;
    tick();
    rstn = 0;
    #1;
    check("f_rsp_valid", rsp_valid, 0);
    check("f_ce1", CE1, 0);
    check("f_rd_ready", rd_ready, 0);
    check("f_wr_ready", wr_ready, 0);
    idle();
    #2 rstn = 1;
    #1;
    check("f_rd_ready_after", rd_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check($sformatf("f_no_stale%0d", i), rsp_valid, 0);
      tick();
    end

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      wr_valid = 1'($urandom_range(0, 1));
      rd_valid = 1'($urandom_range(0, 1));
      wr_addr = 17'($urandom_range(0, 3) << 13) | 17'($urandom_range(0, 15));
      rd_addr = 17'($urandom_range(0, 3) << 13) | 17'($urandom_range(0, 15));
      wr_data = $urandom;
      wr_be = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    idle(); rsp_ready = 1;
    repeat (6) tick();
    @(negedge CLK);
    check("g_drained", rsp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
